// File: rtl/mem_pkg.sv
// Shared types and default widths for the per-core memory/mutex client.
package mem_pkg;

    localparam int DEF_ADR_W  = 16;
    localparam int DEF_DAT_W  = 16;
    localparam int DEF_LOCK_W = 10;
    localparam int WAIT_W     = 16;

    // Core command opcodes
    typedef enum logic [1:0] {
        READ   = 2'd0,
        WRITE  = 2'd1,
        LOCK   = 2'd2,
        UNLOCK = 2'd3
    } op_t;

    // Client sequencer states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        ACC  = 3'd2,
        RDW  = 3'd3,
        LCK  = 3'd4,
        ULK  = 3'd5
    } state_t;

endpackage

// File: rtl/mem_client_if.sv
// Bundle of the core command/response port and the arbiter-facing signals of
// one memory client. The master modport is the client itself; the slave
// modport is the environment (core pipeline plus arbiter slice).
//
// Handshake: a command transfers on a clock edge where cmd_valid and
// cmd_ready are both high. The core holds cmd_valid and the command fields
// stable until that edge. rsp_valid is a one-cycle pulse with no back-pressure.
// Arbiter grants (main_mem_ac, lock_ac) are combinational answers to the
// request outputs in the same cycle and are sampled at the clock edge.
interface mem_client_if #(
    parameter int ADR_W  = mem_pkg::DEF_ADR_W,
    parameter int DAT_W  = mem_pkg::DEF_DAT_W,
    parameter int LOCK_W = mem_pkg::DEF_LOCK_W
) ();
    import mem_pkg::*;

    // core side
    logic              cmd_valid;
    logic              cmd_ready;
    op_t               cmd_op;
    logic [ADR_W-1:0]  cmd_adr;
    logic [DAT_W-1:0]  cmd_wdat;
    logic              rsp_valid;
    logic [DAT_W-1:0]  rsp_rdat;

    // main-memory arbiter side
    logic              main_mem_read_request;
    logic              main_mem_write_request;
    logic              main_mem_ac;
    logic              main_mem_read;
    logic              main_mem_write;
    logic [ADR_W-1:0]  main_mem_read_adr;
    logic [ADR_W-1:0]  main_mem_write_adr;
    logic [DAT_W-1:0]  main_mem_write_dat;
    logic [DAT_W-1:0]  main_mem_dat;

    // mutex arbiter side
    logic [LOCK_W-1:0] lock_adr;
    logic              lock_en;
    logic              unlock_en;
    logic              lock_ac;

    modport master (
        input  cmd_valid, cmd_op, cmd_adr, cmd_wdat,
        output cmd_ready, rsp_valid, rsp_rdat,
        output main_mem_read_request, main_mem_write_request,
        input  main_mem_ac,
        output main_mem_read, main_mem_write,
        output main_mem_read_adr, main_mem_write_adr, main_mem_write_dat,
        input  main_mem_dat,
        output lock_adr, lock_en, unlock_en,
        input  lock_ac
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_adr, cmd_wdat,
        input  cmd_ready, rsp_valid, rsp_rdat,
        input  main_mem_read_request, main_mem_write_request,
        output main_mem_ac,
        input  main_mem_read, main_mem_write,
        input  main_mem_read_adr, main_mem_write_adr, main_mem_write_dat,
        output main_mem_dat,
        input  lock_adr, lock_en, unlock_en,
        output lock_ac
    );

endinterface

// File: rtl/mem_client.sv
// Per-core initiator: takes one READ/WRITE/LOCK/UNLOCK command at a time,
// runs the request/grant/access sequence toward the shared arbiter and
// returns a single-cycle response. All arbiter-facing outputs are registered.
module mem_client
    import mem_pkg::*;
#(
    parameter int ADR_W  = DEF_ADR_W,
    parameter int DAT_W  = DEF_DAT_W,
    parameter int LOCK_W = DEF_LOCK_W
) (
    input  logic              clk,
    input  logic              reset,
    mem_client_if.master      bus,
    output logic [WAIT_W-1:0] wait_cnt,
    output state_t            state_dbg
);

    state_t            state_q;
    op_t               op_q;
    logic [ADR_W-1:0]  adr_q;
    logic [DAT_W-1:0]  wdat_q;
    logic [DAT_W-1:0]  rdat_q;
    logic              cmd_ready_q;
    logic              rsp_valid_q;
    logic              rd_req_q;
    logic              wr_req_q;
    logic              rd_stb_q;
    logic              wr_stb_q;
    logic              lock_en_q;
    logic              unlock_en_q;
    logic [WAIT_W-1:0] wait_q;
    logic              denied;

    // A cycle counts as waiting when a request is up and its grant is not.
    assign denied = ((state_q == REQ) && !bus.main_mem_ac) ||
                    (((state_q == LCK) || (state_q == ULK)) && !bus.lock_ac);

    // Sequencer: state plus every registered handshake output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= READ;
            adr_q       <= '0;
            wdat_q      <= '0;
            rdat_q      <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rd_req_q    <= 1'b0;
            wr_req_q    <= 1'b0;
            rd_stb_q    <= 1'b0;
            wr_stb_q    <= 1'b0;
            lock_en_q   <= 1'b0;
            unlock_en_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q        <= bus.cmd_op;
                        adr_q       <= bus.cmd_adr;
                        wdat_q      <= bus.cmd_wdat;
                        cmd_ready_q <= 1'b0;
                        case (bus.cmd_op)
                            READ: begin
                                state_q  <= REQ;
                                rd_req_q <= 1'b1;
                            end
                            WRITE: begin
                                state_q  <= REQ;
                                wr_req_q <= 1'b1;
                            end
                            LOCK: begin
                                state_q   <= LCK;
                                lock_en_q <= 1'b1;
                            end
                            UNLOCK: begin
                                state_q     <= ULK;
                                unlock_en_q <= 1'b1;
                            end
                        endcase
                    end
                end
                REQ: begin
                    if (bus.main_mem_ac) begin
                        state_q  <= ACC;
                        rd_req_q <= 1'b0;
                        wr_req_q <= 1'b0;
                        rd_stb_q <= (op_q == READ);
                        wr_stb_q <= (op_q != READ);
                    end
                end
                ACC: begin
                    rd_stb_q <= 1'b0;
                    wr_stb_q <= 1'b0;
                    if (op_q == READ) begin
                        state_q <= RDW;
                    end else begin
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                    end
                end
                RDW: begin
                    rdat_q      <= bus.main_mem_dat;
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b1;
                end
                LCK: begin
                    if (bus.lock_ac) begin
                        lock_en_q   <= 1'b0;
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                    end
                end
                ULK: begin
                    if (bus.lock_ac) begin
                        unlock_en_q <= 1'b0;
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    rd_req_q    <= 1'b0;
                    wr_req_q    <= 1'b0;
                    rd_stb_q    <= 1'b0;
                    wr_stb_q    <= 1'b0;
                    lock_en_q   <= 1'b0;
                    unlock_en_q <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of denied-grant cycles; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q <= '0;
        end else if (denied && (wait_q != {WAIT_W{1'b1}})) begin
            wait_q <= wait_q + 1'b1;
        end
    end

    assign bus.cmd_ready              = cmd_ready_q;
    assign bus.rsp_valid              = rsp_valid_q;
    assign bus.rsp_rdat               = rdat_q;
    assign bus.main_mem_read_request  = rd_req_q;
    assign bus.main_mem_write_request = wr_req_q;
    assign bus.main_mem_read          = rd_stb_q;
    assign bus.main_mem_write         = wr_stb_q;
    // The arbiter takes the address from write_adr for both directions.
    assign bus.main_mem_read_adr      = adr_q;
    assign bus.main_mem_write_adr     = adr_q;
    assign bus.main_mem_write_dat     = wdat_q;
    assign bus.lock_adr               = adr_q[LOCK_W-1:0];
    assign bus.lock_en                = lock_en_q;
    assign bus.unlock_en              = unlock_en_q;
    assign wait_cnt                   = wait_q;
    assign state_dbg                  = state_q;

endmodule

// File: tb/tb_mem_client.sv
// Bench for mem_client: arbiter/memory environment with programmable grant
// denial, a table of single commands, and hand sequences for back-to-back
// acceptance, mid-operation reset and wait counter saturation.
module tb_mem_client;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] wait_cnt;
    state_t      state_dbg;

    always #5 clk = ~clk;

    mem_client_if bif ();

    mem_client dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bif),
        .wait_cnt  (wait_cnt),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- arbiter / memory environment ----------------
    int          cyc = 0;
    int          mem_deny = 0;
    int          lock_deny = 0;
    int          mem_run = 0;
    int          lock_run = 0;
    logic        mem_req;
    logic        lock_req;
    logic [15:0] mem_arr [logic [15:0]];
    logic [15:0] mem_dat_q = 16'h0000;

    function automatic logic [15:0] mem_init(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    assign mem_req          = bif.main_mem_read_request | bif.main_mem_write_request;
    assign lock_req         = bif.lock_en | bif.unlock_en;
    assign bif.main_mem_ac  = mem_req && (mem_run >= mem_deny);
    assign bif.lock_ac      = lock_req && (lock_run >= lock_deny);
    assign bif.main_mem_dat = mem_dat_q;

    // Grant run counters, cycle count and a synchronous memory.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        mem_run  <= mem_req ? mem_run + 1 : 0;
        lock_run <= lock_req ? lock_run + 1 : 0;
        if (bif.main_mem_write) mem_arr[bif.main_mem_write_adr] = bif.main_mem_write_dat;
        if (bif.main_mem_read)
            mem_dat_q <= mem_arr.exists(bif.main_mem_read_adr) ? mem_arr[bif.main_mem_read_adr]
                                                                : mem_init(bif.main_mem_read_adr);
    end

    // ---------------- monitor ----------------
    logic [15:0] cur_adr = 16'h0000;
    logic [15:0] cur_wdat = 16'h0000;
    logic        prev_rsp = 1'b0;
    int          rsp_cnt = 0;
    int          rsp_cyc = 0;
    int          req_cycles = 0;
    int          stb_cycles = 0;
    int          rd_cycles = 0;

    always @(negedge clk) begin
        if (reset) begin
            prev_rsp = 1'b0;
        end else begin
            check("one_hot", {31'b0, $countones({bif.main_mem_read_request, bif.main_mem_write_request,
                  bif.main_mem_read, bif.main_mem_write, bif.lock_en, bif.unlock_en}) > 1}, 0);
            check("adr_mirror", bif.main_mem_read_adr, bif.main_mem_write_adr);
            if (bif.main_mem_read || bif.main_mem_write) begin
                stb_cycles++;
                check("stb_adr", bif.main_mem_write_adr, cur_adr);
            end
            if (bif.main_mem_read) rd_cycles++;
            if (bif.main_mem_write) check("stb_wdat", bif.main_mem_write_dat, cur_wdat);
            if (mem_req || lock_req) req_cycles++;
            if (lock_req) check("lock_adr", bif.lock_adr, {22'b0, cur_adr[9:0]});
            if (bif.rsp_valid) begin
                rsp_cnt++;
                rsp_cyc = cyc;
                check("rsp_double", prev_rsp, 0);
                check("rsp_ready", bif.cmd_ready, 1);
                check("rsp_state", state_dbg, IDLE);
                check("rsp_adr_hold", bif.main_mem_write_adr, cur_adr);
                if (exp_q.size() == 0) check("rsp_unexpected", 1, 0);
                else check("rsp_rdat", bif.rsp_rdat, exp_q.pop_front());
            end
            prev_rsp = bif.rsp_valid;
        end
    end

    // ---------------- driver ----------------
    task automatic run_cmd(input string tag, input op_t op, input logic [15:0] adr,
                           input logic [15:0] wdat, input int deny, input int exp_lat,
                           input logic [15:0] exp_rdat, input logic [15:0] exp_winc);
        int          acc_cyc;
        int          r0, q0, s0;
        logic [15:0] w0;
        bit          got;
        if (op == READ || op == WRITE) mem_deny = deny;
        else lock_deny = deny;
        @(negedge clk); #1;
        check({tag, "_ready"}, bif.cmd_ready, 1);
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = op;
        bif.cmd_adr   = adr;
        bif.cmd_wdat  = wdat;
        cur_adr       = adr;
        cur_wdat      = wdat;
        exp_q.push_back(exp_rdat);
        r0 = rsp_cnt; q0 = req_cycles; s0 = stb_cycles; w0 = wait_cnt;
        @(posedge clk); #1;
        acc_cyc = cyc;
        bif.cmd_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < deny + 20 && !got; i++) begin
            @(negedge clk); #1;
            if (rsp_cnt != r0) got = 1'b1;
        end
        if (!got) begin
            check({tag, "_timeout"}, 0, 1);
            void'(exp_q.pop_back());
        end else begin
            check({tag, "_latency"}, rsp_cyc - acc_cyc + 1, exp_lat);
            check({tag, "_wait_inc"}, wait_cnt - w0, exp_winc);
            check({tag, "_req_cycles"}, req_cycles - q0, deny + 1);
            check({tag, "_strobes"}, stb_cycles - s0, (op == READ || op == WRITE) ? 1 : 0);
        end
    endtask

    typedef struct {
        op_t         op;
        logic [15:0] adr;
        logic [15:0] wdat;
        int          deny;
        int          lat;
        logic [15:0] rdat;
        logic [15:0] winc;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int          r0, s0;
        logic [15:0] w0;
        bit          got;

        bif.cmd_valid = 1'b0;
        bif.cmd_op    = READ;
        bif.cmd_adr   = 16'h0000;
        bif.cmd_wdat  = 16'h0000;

        //          op      adr       wdat      deny lat rsp_rdat  wait inc
        vecs[0]  = '{WRITE,  16'h0040, 16'hBEEF, 0,   3,  16'h0000, 16'd0};
        vecs[1]  = '{READ,   16'h0040, 16'h0000, 3,   7,  16'hBEEF, 16'd3};
        vecs[2]  = '{LOCK,   16'hFC05, 16'h0000, 2,   4,  16'hBEEF, 16'd2};
        vecs[3]  = '{UNLOCK, 16'hFC05, 16'h0000, 0,   2,  16'hBEEF, 16'd0};
        vecs[4]  = '{WRITE,  16'h1234, 16'hA5A5, 1,   4,  16'hBEEF, 16'd1};
        vecs[5]  = '{READ,   16'h1234, 16'h0000, 0,   4,  16'hA5A5, 16'd0};
        vecs[6]  = '{READ,   16'h0077, 16'h0000, 0,   4,  16'h5A2D, 16'd0};
        vecs[7]  = '{UNLOCK, 16'h03FF, 16'h0000, 1,   3,  16'h5A2D, 16'd1};
        vecs[8]  = '{WRITE,  16'hFFFF, 16'h0001, 5,   8,  16'h5A2D, 16'd5};
        vecs[9]  = '{READ,   16'hFFFF, 16'h0000, 0,   4,  16'h0001, 16'd0};
        vecs[10] = '{WRITE,  16'h0040, 16'h0000, 0,   3,  16'h0001, 16'd0};
        vecs[11] = '{READ,   16'h0040, 16'h0000, 2,   6,  16'h0000, 16'd2};

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", bif.cmd_ready, 1);
        check("rst_state", state_dbg, IDLE);
        check("rst_outs", {bif.rsp_valid, bif.main_mem_read_request, bif.main_mem_write_request,
              bif.main_mem_read, bif.main_mem_write, bif.lock_en, bif.unlock_en}, 0);
        check("rst_rdat", bif.rsp_rdat, 0);
        check("rst_wait", wait_cnt, 0);
        check("rst_adr", bif.main_mem_write_adr, 0);
        check("rst_wdat", bif.main_mem_write_dat, 0);
        check("rst_lock_adr", bif.lock_adr, 0);
        #1 reset = 1'b0;
        @(negedge clk);
        check("post_rst_ready", bif.cmd_ready, 1);

        // ---- table of single commands ----
        for (int i = 0; i < 12; i++)
            run_cmd($sformatf("v%0d", i), vecs[i].op, vecs[i].adr, vecs[i].wdat,
                    vecs[i].deny, vecs[i].lat, vecs[i].rdat, vecs[i].winc);
        check("wait_total", wait_cnt, 16'd14);

        // ---- second READ held on cmd_valid while first is busy ----
        mem_deny = 2;
        @(negedge clk); #1;
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = READ;
        bif.cmd_adr   = 16'h0040;
        cur_adr       = 16'h0040;
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'hA5A5);
        r0 = rsp_cnt; s0 = rd_cycles;
        @(posedge clk); #1;
        bif.cmd_adr = 16'h1234;
        check("b2b_first_req", state_dbg, REQ);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk); #1;
            if (bif.cmd_ready) got = 1'b1;
        end
        check("b2b_ready_seen", got, 1);
        check("b2b_accept_with_rsp", bif.rsp_valid, 1);
        check("b2b_first_done", rsp_cnt - r0, 1);
        cur_adr = 16'h1234;
        @(posedge clk); #1;
        bif.cmd_valid = 1'b0;
        check("b2b_second_req", state_dbg, REQ);
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk); #1;
            if (rsp_cnt - r0 == 2) got = 1'b1;
        end
        check("b2b_two_rsps", got, 1);
        repeat (3) @(negedge clk);
        check("b2b_read_strobes", rd_cycles - s0, 2);

        // ---- reset while waiting for a grant ----
        mem_deny = 1000;
        @(negedge clk); #1;
        bif.cmd_valid = 1'b1;
        bif.cmd_op    = READ;
        bif.cmd_adr   = 16'h0777;
        cur_adr       = 16'h0777;
        @(posedge clk); #1;
        bif.cmd_valid = 1'b0;
        @(negedge clk); #1;
        check("abort_in_req", {state_dbg, bif.main_mem_read_request}, {REQ, 1'b1});
        w0 = wait_cnt;
        check("abort_wait_nonzero", w0 != 0, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_state", state_dbg, IDLE);
        check("abort_ready", bif.cmd_ready, 1);
        check("abort_outs", {bif.rsp_valid, bif.main_mem_read_request, bif.main_mem_write_request,
              bif.main_mem_read, bif.main_mem_write, bif.lock_en, bif.unlock_en}, 0);
        check("abort_wait", wait_cnt, 0);
        check("abort_rdat", bif.rsp_rdat, 0);
        cur_adr = 16'h0000;
        repeat (4) @(negedge clk);
        check("abort_no_rsp", exp_q.size(), 0);

        run_cmd("post_abort_wr", WRITE, 16'h0100, 16'h1357, 0, 3, 16'h0000, 16'd0);

        // ---- wait counter saturation ----
        run_cmd("sat_lock", LOCK, 16'h0005, 16'h0000, 65540, 65542, 16'h0000, 16'hFFFF);
        check("sat_value", wait_cnt, 16'hFFFF);
        run_cmd("sat_hold", UNLOCK, 16'h0005, 16'h0000, 1, 3, 16'h0000, 16'd0);
        check("sat_still", wait_cnt, 16'hFFFF);

        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
